axis_packet_fifo: RTL and testbench

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/skid_loader.sv | 60 ++++++
 rtl/axis_packet_fifo.sv | 145 ++++++++++++++
 tb/tb_axis_packet_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer arithmetic helpers and default thresholds
// shared by the packet FIFO and its users.
package fifo_pkg;

   function automatic int afull_default(int abits);
      return (1 << abits) - 2;
   endfunction

   // Pointers carry one wrap bit above the address bits.
   function automatic int unsigned ptr_diff(int unsigned a,
                                            int unsigned b,
                                            int abits);
      return (a - b) & ((32'd1 << (abits + 1)) - 32'd1);
   endfunction

   function automatic logic ptr_full(int unsigned w,
                                     int unsigned r,
                                     int abits);
      return ptr_diff(w, r, abits) == (32'd1 << abits);
   endfunction

   function automatic logic ptr_empty(int unsigned w,
                                      int unsigned r,
                                      int abits);
      return ptr_diff(w, r, abits) == 32'd0;
   endfunction

endpackage

// File: rtl/skid_loader.sv
// skid_loader: two-entry output skid stage with a registered in_ready.
// BYPASS forwards input combinationally when empty; LOADER admits only when empty.
module skid_loader #(
   parameter int WIDTH  = 8,
   parameter int BYPASS = 0,
   parameter int LOADER = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] d0_q, d0_d;
   logic [WIDTH-1:0] d1_q, d1_d;
   logic             byp;
   logic             push;
   logic             pop;

   assign byp       = (BYPASS != 0) && (cnt_q == 2'd0);
   assign in_ready  = (LOADER != 0) ? (cnt_q == 2'd0)
                                    : (cnt_q != 2'd2);
   assign out_valid = byp ? in_valid : (cnt_q != 2'd0);
   assign out_data  = byp ? in_data : d0_q;
   assign pop       = out_valid && out_ready && !byp;
   assign push      = in_valid && in_ready && !(byp && out_ready);

   always_comb begin
      cnt_d = cnt_q;
      d0_d  = d0_q;
      d1_d  = d1_q;
      if (pop) begin
         d0_d  = d1_q;
         cnt_d = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_d == 2'd0) d0_d = in_data;
         else               d1_d = in_data;
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         d0_q  <= '0;
         d1_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         d0_q  <= d0_d;
         d1_q  <= d1_d;
      end
   end

endmodule

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: store-and-forward AXI-Stream packet FIFO.
// Define PKT_DROP_EN to let s_tdrop discard the uncommitted packet.
module axis_packet_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ABITS = 4,
   parameter int AFULL = afull_default(ABITS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_tvalid,
   output logic             s_tready,
   input  logic             s_tlast,
   input  logic             s_tdrop,
   input  logic [WIDTH-1:0] s_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic [WIDTH-1:0] m_tdata,
   output logic [ABITS:0]   level_o,
   output logic [ABITS:0]   pkts_o,
   output logic             afull_o,
   output logic             ovf_o
);

   localparam int          PW    = ABITS + 1;
   localparam int unsigned DEPTH = 1 << ABITS;

   logic [WIDTH:0]  mem_q [DEPTH];
   logic [WIDTH:0]  rd_word_q;
   logic [WIDTH:0]  sk_out;
   logic [PW-1:0]   waddr_q, waddr_d;
   logic [PW-1:0]   caddr_q, caddr_d;
   logic [PW-1:0]   raddr_q, raddr_d;
   logic [PW-1:0]   level_q, level_d;
   logic [PW-1:0]   pkts_q, pkts_d;
   logic            rd_valid_q, rd_valid_d;
   logic            s_tready_q, s_tready_d;
   logic            afull_q, afull_d;
   logic            ovf_q, ovf_d;
   logic            accept, drop, wr_en, commit;
   logic            force_cut, fetch, m_fire, sk_ready;

   assign accept = s_tvalid && s_tready_q;

`ifdef PKT_DROP_EN
   assign drop = accept && s_tdrop;
`else
   logic unused_tdrop;
   assign unused_tdrop = s_tdrop;
   assign drop = 1'b0;
`endif

   // Full with nothing committed: the packet cannot fit, so cut through.
   assign force_cut = ptr_full(32'(waddr_q), 32'(raddr_q), ABITS)
                   && (raddr_q == caddr_q);
   assign fetch     = !ptr_empty(32'(caddr_q), 32'(raddr_q), ABITS)
                   && (!rd_valid_q || sk_ready);
   assign m_fire    = m_tvalid && m_tready;

   always_comb begin
      waddr_d = waddr_q;
      caddr_d = caddr_q;
      raddr_d = raddr_q;
      level_d = level_q;
      pkts_d  = pkts_q;
      wr_en   = accept && !drop;
      commit  = wr_en && s_tlast;
      if (wr_en) begin
         waddr_d = waddr_q + PW'(1);
         level_d = level_q + PW'(1);
      end
      if (drop) begin
         waddr_d = caddr_q;
         level_d = level_q - PW'(ptr_diff(32'(waddr_q), 32'(caddr_q), ABITS));
      end
      if (m_fire) level_d = level_d - PW'(1);
      if (commit) begin
         caddr_d = waddr_d;
         pkts_d  = pkts_q + PW'(1);
      end else if (force_cut) begin
         caddr_d = waddr_q;
      end
      if (m_fire && m_tlast) pkts_d = pkts_d - PW'(1);
      if (fetch) raddr_d = raddr_q + PW'(1);
      rd_valid_d = fetch || (rd_valid_q && !sk_ready);
      s_tready_d = !ptr_full(32'(waddr_d), 32'(raddr_d), ABITS);
      afull_d    = 32'(level_d) >= 32'(AFULL);
      ovf_d      = force_cut;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         waddr_q    <= '0;
         caddr_q    <= '0;
         raddr_q    <= '0;
         level_q    <= '0;
         pkts_q     <= '0;
         rd_valid_q <= 1'b0;
         s_tready_q <= 1'b0;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         waddr_q    <= waddr_d;
         caddr_q    <= caddr_d;
         raddr_q    <= raddr_d;
         level_q    <= level_d;
         pkts_q     <= pkts_d;
         rd_valid_q <= rd_valid_d;
         s_tready_q <= s_tready_d;
         afull_q    <= afull_d;
         ovf_q      <= ovf_d;
      end
   end

   // Plain RAM: no reset so it maps onto block memory.
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[waddr_q[ABITS-1:0]] <= {s_tlast, s_tdata};
      if (fetch) rd_word_q <= mem_q[raddr_q[ABITS-1:0]];
   end

   skid_loader #(
      .WIDTH (WIDTH + 1),
      .BYPASS(0),
      .LOADER(0)
   ) u_skid (
      .clock    (clock),
      .reset    (reset),
      .in_valid (rd_valid_q),
      .in_ready (sk_ready),
      .in_data  (rd_word_q),
      .out_valid(m_tvalid),
      .out_ready(m_tready),
      .out_data (sk_out)
   );

   assign {m_tlast, m_tdata} = sk_out;
   assign s_tready = s_tready_q;
   assign level_o  = level_q;
   assign pkts_o   = pkts_q;
   assign afull_o  = afull_q;
   assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: directed vectors plus a queue-based packet model
// checked against the FIFO outputs every cycle.
module tb_axis_packet_fifo;

   localparam int DEPTH = 16;
   localparam int AFULL = 14;

   logic       clock;
   logic       reset = 1'b1;
   logic       s_tvalid = 1'b0;
   logic       s_tready;
   logic       s_tlast = 1'b0;
   logic       s_tdrop = 1'b0;
   logic [7:0] s_tdata = 8'h00;
   logic       m_tvalid;
   logic       m_tready = 1'b0;
   logic       m_tlast;
   logic [7:0] m_tdata;
   logic [4:0] level_o;
   logic [4:0] pkts_o;
   logic       afull_o;
   logic       ovf_o;

   int n_chk = 0;
   int n_fail = 0;

   axis_packet_fifo #(.WIDTH(8), .ABITS(4)) dut (
      .clock   (clock),
      .reset   (reset),
      .s_tvalid(s_tvalid),
      .s_tready(s_tready),
      .s_tlast (s_tlast),
      .s_tdrop (s_tdrop),
      .s_tdata (s_tdata),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tlast (m_tlast),
      .m_tdata (m_tdata),
      .level_o (level_o),
      .pkts_o  (pkts_o),
      .afull_o (afull_o),
      .ovf_o   (ovf_o)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: every non-dropped input beat, in order, plus counters.
   logic [8:0] sb[$];
   int  m_avail = 0;
   int  m_unc = 0;
   int  m_lvl = 0;
   int  m_pkts = 0;
   bit  m_pend = 1'b0;
   bit  m_ovf = 1'b0;
   bit  prev_stall = 1'b0;
   logic [8:0] prev_word = '0;

   always @(negedge clock) begin
      if (reset) begin
         chk("rst_m_tvalid", int'(m_tvalid), 0);
         chk("rst_s_tready", int'(s_tready), 0);
         chk("rst_level", int'(level_o), 0);
         chk("rst_pkts", int'(pkts_o), 0);
         sb.delete();
         m_avail = 0; m_unc = 0; m_lvl = 0; m_pkts = 0;
         m_pend = 1'b0; m_ovf = 1'b0; prev_stall = 1'b0;
      end else begin
         chk("mon_level", int'(level_o), m_lvl);
         chk("mon_pkts", int'(pkts_o), m_pkts);
         chk("mon_afull", int'(afull_o), int'(m_lvl >= AFULL));
         chk("mon_ovf", int'(ovf_o), int'(m_ovf));
         if (m_avail == 0) chk("mon_uncommitted_out", int'(m_tvalid), 0);
         if (prev_stall) begin
            chk("mon_hold_valid", int'(m_tvalid), 1);
            chk("mon_hold_data", int'({m_tlast, m_tdata}), int'(prev_word));
         end
         prev_stall = m_tvalid && !m_tready;
         prev_word  = {m_tlast, m_tdata};
         // Predict what the coming edge does.
         m_ovf = 1'b0;
         if (m_pend) begin
            m_avail += m_unc;
            m_unc = 0;
            m_ovf = 1'b1;
            m_pend = 1'b0;
         end
         if (m_tvalid && m_tready && m_avail > 0) begin
            if (sb.size() == 0) begin
               chk("mon_sb_empty", 1, 0);
            end else begin
               chk("mon_out_word", int'({m_tlast, m_tdata}), int'(sb[0]));
               void'(sb.pop_front());
            end
            m_avail--;
            m_lvl--;
            if (m_tlast) m_pkts--;
         end
         if (s_tvalid && s_tready) begin
`ifdef PKT_DROP_EN
            if (s_tdrop) begin
               for (int i = 0; i < m_unc; i++) void'(sb.pop_back());
               m_lvl -= m_unc;
               m_unc = 0;
            end else
`endif
            begin
               sb.push_back({s_tlast, s_tdata});
               m_lvl++;
               m_unc++;
               if (s_tlast) begin
                  m_avail += m_unc;
                  m_unc = 0;
                  m_pkts++;
               end
            end
         end
         if (m_unc == DEPTH) m_pend = 1'b1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, input logic dr);
      bit a;
      int t = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      s_tdrop  = dr;
      do begin
         a = s_tready;
         step();
         t++;
      end while (!a && t < 200);
      if (!a) chk("send_timeout", 0, 1);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdrop  = 1'b0;
   endtask

   task automatic expect_beat(input logic [7:0] d, input logic l, input string nm);
      int t = 0;
      while (!m_tvalid && t < 30) begin
         step();
         t++;
      end
      if (!m_tvalid) begin
         chk({nm, "_timeout"}, 0, 1);
      end else begin
         chk(nm, int'({m_tlast, m_tdata}), int'({l, d}));
      end
      step();
   endtask

   int  cnt;
   bit  done = 1'b0;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and release.
      #2;
      chk("reset_s_tready", int'(s_tready), 0);
      chk("reset_m_tvalid", int'(m_tvalid), 0);
      chk("reset_level", int'(level_o), 0);
      step(); step();
      reset = 1'b0;
      chk("pre_release_s_tready", int'(s_tready), 0);
      step();
      chk("release_s_tready", int'(s_tready), 1);

      // Three-beat packet, latency and order.
      m_tready = 1'b1;
      send_beat(8'h11, 1'b0, 1'b0);
      send_beat(8'h22, 1'b0, 1'b0);
      send_beat(8'h33, 1'b1, 1'b0);
      chk("p1_pkts_commit", int'(pkts_o), 1);
      chk("p1_level", int'(level_o), 3);
      chk("p1_valid_e0", int'(m_tvalid), 0);
      step();
      chk("p1_valid_e1", int'(m_tvalid), 0);
      step();
      chk("p1_valid_e2", int'(m_tvalid), 1);
      chk("p1_beat0", int'({m_tlast, m_tdata}), 'h011);
      step();
      chk("p1_beat1", int'({m_tlast, m_tdata}), 'h022);
      step();
      chk("p1_beat2", int'({m_tlast, m_tdata}), 'h133);
      chk("p1_pkts_before", int'(pkts_o), 1);
      step();
      chk("p1_valid_done", int'(m_tvalid), 0);
      chk("p1_pkts_done", int'(pkts_o), 0);
      chk("p1_level_done", int'(level_o), 0);

      // Oversize packet: forced cut-through.
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) send_beat(8'(i), 1'b0, 1'b0);
      chk("ovs_s_tready", int'(s_tready), 0);
      chk("ovs_level", int'(level_o), 16);
      chk("ovs_afull", int'(afull_o), 1);
      chk("ovs_ovf_before", int'(ovf_o), 0);
      step();
      chk("ovs_ovf_pulse", int'(ovf_o), 1);
      step();
      chk("ovs_ovf_clear", int'(ovf_o), 0);
      chk("ovs_pkts", int'(pkts_o), 0);
      m_tready = 1'b1;
      for (int i = 0; i < 16; i++) expect_beat(8'(i), 1'b0, "ovs_drain");
      send_beat(8'hAA, 1'b1, 1'b0);
      chk("ovs_tail_pkts", int'(pkts_o), 1);
      expect_beat(8'hAA, 1'b1, "ovs_tail");
      chk("ovs_end_pkts", int'(pkts_o), 0);
      chk("ovs_end_level", int'(level_o), 0);

      // Drop of an uncommitted packet (drop with tlast).
      m_tready = 1'b0;
      send_beat(8'hA1, 1'b0, 1'b0);
      send_beat(8'hA2, 1'b1, 1'b0);
      send_beat(8'hB1, 1'b0, 1'b0);
      send_beat(8'hB2, 1'b0, 1'b0);
      send_beat(8'hB3, 1'b0, 1'b0);
      chk("drop_level_pre", int'(level_o), 5);
      send_beat(8'hB4, 1'b1, 1'b1);
`ifdef PKT_DROP_EN
      chk("drop_level_post", int'(level_o), 2);
      chk("drop_pkts", int'(pkts_o), 1);
`else
      chk("nodrop_level_post", int'(level_o), 6);
      chk("nodrop_pkts", int'(pkts_o), 2);
`endif
      m_tready = 1'b1;
      expect_beat(8'hA1, 1'b0, "drop_a1");
      expect_beat(8'hA2, 1'b1, "drop_a2");
`ifdef PKT_DROP_EN
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_tvalid) cnt++;
         step();
      end
      chk("drop_no_b_beats", cnt, 0);
`else
      expect_beat(8'hB1, 1'b0, "nodrop_b1");
      expect_beat(8'hB2, 1'b0, "nodrop_b2");
      expect_beat(8'hB3, 1'b0, "nodrop_b3");
      expect_beat(8'hB4, 1'b1, "nodrop_b4");
`endif
      chk("drop_end_level", int'(level_o), 0);
      chk("drop_end_pkts", int'(pkts_o), 0);

      // Random packets against random backpressure.
      fork
         begin
            for (int p = 0; p < 200; p++) begin
               int len;
               len = int'($urandom_range(1, 8));
               for (int b = 0; b < len; b++)
                  send_beat(8'($urandom), b == len - 1, 1'b0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               m_tready = 1'($urandom_range(0, 1));
               step();
            end
         end
      join
      m_tready = 1'b1;
      cnt = 0;
      while ((level_o != 0 || m_tvalid) && cnt < 200) begin
         step();
         cnt++;
      end
      chk("rand_level_zero", int'(level_o), 0);
      chk("rand_pkts_zero", int'(pkts_o), 0);
      chk("rand_sb_drained", sb.size(), 0);

      // Reset in the middle of the second packet.
      m_tready = 1'b0;
      send_beat(8'hC1, 1'b0, 1'b0);
      send_beat(8'hC2, 1'b0, 1'b0);
      send_beat(8'hC3, 1'b1, 1'b0);
      send_beat(8'hD1, 1'b0, 1'b0);
      send_beat(8'hD2, 1'b0, 1'b0);
      chk("mid_level", int'(level_o), 5);
      reset = 1'b1;
      #1;
      chk("async_m_tvalid", int'(m_tvalid), 0);
      chk("async_m_tdata", int'(m_tdata), 0);
      chk("async_m_tlast", int'(m_tlast), 0);
      chk("async_s_tready", int'(s_tready), 0);
      chk("async_level", int'(level_o), 0);
      chk("async_pkts", int'(pkts_o), 0);
      chk("async_afull", int'(afull_o), 0);
      chk("async_ovf", int'(ovf_o), 0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_s_tready", int'(s_tready), 1);
      m_tready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (m_tvalid) cnt++;
         step();
      end
      chk("post_rst_no_beats", cnt, 0);
      chk("post_rst_level", int'(level_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
